alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//  CR16 execute stage wrapping one alu instance. Accepts decoded operands over a valid/ready
//  handshake and registers the ALU result for writeback. Holds the processor status register
//  (PSR), updating it from the ALU O_STATUS under a per-instruction flag mask. Evaluates CR16
//  condition codes against the PSR for Bcond/Jcond/Scond.
// PARAMETERS
//  DATA_WIDTH  16  operand/result width; must equal the alu width (16)
//  REG_IDX_W   4   destination register index width
// PORTS
//  I_CLK        in   1   clock, rising edge
//  I_NRESET     in   1   asynchronous active-low reset
//  I_VALID      in   1   upstream operands valid
//  O_READY      out  1   stage can accept an instruction this cycle
//  I_OPCODE     in   4   alu opcode (0 ADD ... 13 ARSH)
//  I_A, I_B     in   16  alu operands; SUB/SUBU produce I_B - I_A
//  I_RDEST      in   4   destination register index, carried with the result
//  I_FLAG_MASK  in   5   PSR bits this instruction may update
//  I_PSR_LOAD   in   1   direct PSR write (LPR); not handshaked
//  I_PSR_DATA   in   5   value for I_PSR_LOAD
//  O_VALID      out  1   registered result valid
//  I_READY      in   1   downstream (writeback) accepts the result
//  O_RESULT     out  16  registered alu O_C
//  O_RDEST      out  4   registered I_RDEST
//  O_PSR        out  5   {N,Z,F,L,C} = bits [4:0]; same indexing as alu O_STATUS
//  I_COND       in   4   condition code to evaluate
//  O_COND_TRUE  out  1   combinational condition result from current O_PSR
// BEHAVIOUR
//  - Reset (async, I_NRESET=0): O_VALID=0, O_RESULT=0, O_RDEST=0, O_PSR=0, skid entry cleared.
//    Any held/in-flight result is discarded; no PSR update occurs from it.
//  - alu I_ENABLE tied 1; alu driven combinationally from I_A/I_B/I_OPCODE.
//  - Accept = I_VALID & O_READY. On accept edge: result register <= {O_C, I_RDEST}, O_VALID<=1.
//    Latency: 1 cycle from accept to O_VALID.
//  - Output handshake: O_VALID=1 holds O_RESULT/O_RDEST stable until I_VALID... I_READY=1 edge.
//    Output fires on O_VALID & I_READY; O_VALID drops unless a new accept occurs the same edge.
//  - Base O_READY = ~O_VALID | I_READY (combinational); simultaneous fire+accept keeps full throughput.
//  - PSR update on accept edge: O_PSR <= (O_PSR & ~I_FLAG_MASK) | (O_STATUS & I_FLAG_MASK).
//    PSR updates at accept, not at output fire, so the next instruction sees it.
//  - I_PSR_LOAD=1: O_PSR <= I_PSR_DATA, overriding any same-edge accept update.
//  - Conditions (I_COND -> O_COND_TRUE): 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 HI L; 5 LS ~L;
//    6 GT N; 7 LE ~N; 8 FS F; 9 FC ~F; 10 LO ~L&~Z; 11 HS L|Z; 12 LT ~N&~Z; 13 GE N|Z;
//    14 UC 1; 15 never 0.
// CONFIGURATION
//  ALU_EXEC_SKID_EN defined: adds one skid entry (two-deep buffer).
//    - O_READY is registered: O_READY = ~skid_full.
//    - Accept while output stalled parks into skid. Skid drains to output on the next output fire.
//    - Order is preserved. PSR is still updated at accept.
//  ALU_EXEC_SKID_EN undefined: single output register, combinational O_READY as above.
// TESTING
//  1 ADD: A=0x7FFF B=0x0001 op0 mask=5'h1F, I_READY=1 -> next cycle O_VALID=1 O_RESULT=0x8000,
//    O_PSR[4]=1 O_PSR[2]=1 O_PSR[3]=0.
//  2 SUBU: A=5 B=3 op5 mask=5'h1F -> O_RESULT=0xFFFE, O_PSR[1]=1 O_PSR[0]=1;
//    I_COND=4 (HI) -> O_COND_TRUE=1.
//  3 Mask: PSR=5'b01000, ADDU 0xFFFF+1 with mask=5'b00001 -> O_PSR=5'b01001 (Z retained, C set).
//  4 Backpressure: I_READY=0, three back-to-back accepts (results 1,2,3) ->
//    base: O_READY=0 after first, O_RESULT=1 held;
//    SKID_EN: two accepted, drains 1 then 2 in order when I_READY=1.
//  5 PSR load vs accept same edge: I_PSR_LOAD=1 I_PSR_DATA=5'b10000 plus ADD result 0 ->
//    O_PSR=5'b10000, O_RESULT=0.
//  6 Reset mid-stall: O_VALID=1 I_READY=0, pulse I_NRESET low ->
//    O_VALID=0, O_PSR=0 immediately, O_READY=1 after release.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: CR16 execute stage around one alu instance. It takes decoded
// operands over a valid/ready handshake, registers the alu result for writeback,
// holds the PSR {N,Z,F,L,C}, and evaluates CR16 condition codes against the PSR.
// Latency: 1 cycle from accept to O_VALID.
// Backpressure: by default O_READY = ~O_VALID | I_READY (combinational), so a
// result can fire and a new instruction can be accepted on the same edge.
// Optional feature ALU_EXEC_SKID_EN: when defined, the stage gets a second buffer
// entry (a skid entry) and O_READY becomes ~skid_full, driven straight from a flop.
// Ports:
//   I_CLK, I_NRESET            clock (rising edge) and asynchronous active-low reset
//   I_VALID/O_READY            upstream handshake: I_OPCODE, I_A, I_B, I_RDEST, I_FLAG_MASK
//   I_PSR_LOAD/I_PSR_DATA      direct PSR write (LPR); wins over a same-edge accept update
//   O_VALID/I_READY            downstream handshake: O_RESULT, O_RDEST
//   O_PSR                      processor status {N,Z,F,L,C} = bits [4:0]
//   I_COND/O_COND_TRUE         condition code in, combinational result from O_PSR
// alu opcodes: 0 ADD 1 ADDU 2 ADDC 3 MUL 4 SUB 5 SUBU 6 SUBC 7 CMP 8 AND 9 OR
//   10 XOR 11 NOT(A) 12 LSH(B<<A[3:0]) 13 ARSH(B>>>A[3:0]); 14,15 produce 0, status 0.
//   The subtract family computes B - A (ADDC/SUBC use the PSR carry as carry/borrow in).
module alu_exec_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_IDX_W  = 4
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_VALID,
  output logic                  O_READY,
  input  logic [3:0]            I_OPCODE,
  input  logic [DATA_WIDTH-1:0] I_A,
  input  logic [DATA_WIDTH-1:0] I_B,
  input  logic [REG_IDX_W-1:0]  I_RDEST,
  input  logic [4:0]            I_FLAG_MASK,
  input  logic                  I_PSR_LOAD,
  input  logic [4:0]            I_PSR_DATA,
  output logic                  O_VALID,
  input  logic                  I_READY,
  output logic [DATA_WIDTH-1:0] O_RESULT,
  output logic [REG_IDX_W-1:0]  O_RDEST,
  output logic [4:0]            O_PSR,
  input  logic [3:0]            I_COND,
  output logic                  O_COND_TRUE
);
  logic [DATA_WIDTH-1:0] w_alu_c;
  logic [4:0]            w_alu_status;
  logic                  w_accept;
  logic                  w_fire;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic [REG_IDX_W-1:0]  r_rdest;
  logic [4:0]            r_psr;

  alu #(.WIDTH(DATA_WIDTH)) u_alu (
    .I_ENABLE (1'b1),
    .I_CIN    (r_psr[0]),
    .I_OPCODE (I_OPCODE),
    .I_A      (I_A),
    .I_B      (I_B),
    .O_C      (w_alu_c),
    .O_STATUS (w_alu_status)
  );

  assign w_fire   = r_valid & I_READY;
  assign w_accept = I_VALID & O_READY;

`ifdef ALU_EXEC_SKID_EN
  logic                  r_skid_vld;
  logic [DATA_WIDTH-1:0] r_skid_result;
  logic [REG_IDX_W-1:0]  r_skid_rdest;

  assign O_READY = ~r_skid_vld;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_valid       <= 1'b0;
      r_result      <= '0;
      r_rdest       <= '0;
      r_skid_vld    <= 1'b0;
      r_skid_result <= '0;
      r_skid_rdest  <= '0;
    end else if (!r_valid || w_fire) begin
      // Output slot frees up this edge. The skid entry is older than anything
      // arriving now, so it refills the slot first. A full skid entry forces
      // O_READY low, so no accept can happen at the same time.
      if (r_skid_vld) begin
        r_valid    <= 1'b1;
        r_result   <= r_skid_result;
        r_rdest    <= r_skid_rdest;
        r_skid_vld <= 1'b0;
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_result <= w_alu_c;
        r_rdest  <= I_RDEST;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Output is stalled: park the new result behind it.
      r_skid_vld    <= 1'b1;
      r_skid_result <= w_alu_c;
      r_skid_rdest  <= I_RDEST;
    end
  end
`else
  assign O_READY = ~r_valid | I_READY;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_rdest  <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= w_alu_c;
      r_rdest  <= I_RDEST;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end
`endif

  // The PSR updates when an instruction is accepted, not when its result fires,
  // so the next instruction already sees the new flags. LPR overrides.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_psr <= '0;
    end else if (I_PSR_LOAD) begin
      r_psr <= I_PSR_DATA;
    end else if (w_accept) begin
      r_psr <= (r_psr & ~I_FLAG_MASK) | (w_alu_status & I_FLAG_MASK);
    end
  end

  always_comb begin
    O_COND_TRUE = 1'b0;
    case (I_COND)
      4'd0:  O_COND_TRUE = r_psr[3];
      4'd1:  O_COND_TRUE = ~r_psr[3];
      4'd2:  O_COND_TRUE = r_psr[0];
      4'd3:  O_COND_TRUE = ~r_psr[0];
      4'd4:  O_COND_TRUE = r_psr[1];
      4'd5:  O_COND_TRUE = ~r_psr[1];
      4'd6:  O_COND_TRUE = r_psr[4];
      4'd7:  O_COND_TRUE = ~r_psr[4];
      4'd8:  O_COND_TRUE = r_psr[2];
      4'd9:  O_COND_TRUE = ~r_psr[2];
      4'd10: O_COND_TRUE = ~r_psr[1] & ~r_psr[3];
      4'd11: O_COND_TRUE = r_psr[1] | r_psr[3];
      4'd12: O_COND_TRUE = ~r_psr[4] & ~r_psr[3];
      4'd13: O_COND_TRUE = r_psr[4] | r_psr[3];
      4'd14: O_COND_TRUE = 1'b1;
      default: O_COND_TRUE = 1'b0;
    endcase
  end

  assign O_VALID  = r_valid;
  assign O_RESULT = r_result;
  assign O_RDEST  = r_rdest;
  assign O_PSR    = r_psr;
endmodule

// alu: purely combinational CR16 ALU. O_STATUS = {N,Z,F,L,C}.
// For the subtract family, C is the borrow, L is unsigned B < A, and N is
// signed B < A. For all other opcodes, N is the result MSB.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             I_ENABLE,
  input  logic             I_CIN,
  input  logic [3:0]       I_OPCODE,
  input  logic [WIDTH-1:0] I_A,
  input  logic [WIDTH-1:0] I_B,
  output logic [WIDTH-1:0] O_C,
  output logic [4:0]       O_STATUS
);
  localparam int MSB = WIDTH - 1;

  logic             w_add_cin;
  logic             w_sub_bin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_c;
  logic             w_n, w_z, w_f, w_l, w_cy;
  logic             w_is_sub;

  assign w_add_cin = (I_OPCODE == 4'd2) & I_CIN;
  assign w_sub_bin = (I_OPCODE == 4'd6) & I_CIN;
  // One extra bit catches carry out, or the borrow when the difference goes negative.
  assign w_sum  = {1'b0, I_B} + {1'b0, I_A} + {{WIDTH{1'b0}}, w_add_cin};
  assign w_diff = {1'b0, I_B} - {1'b0, I_A} - {{WIDTH{1'b0}}, w_sub_bin};

  always_comb begin
    w_c      = '0;
    w_f      = 1'b0;
    w_l      = 1'b0;
    w_cy     = 1'b0;
    w_is_sub = 1'b0;
    case (I_OPCODE)
      4'd0, 4'd1, 4'd2: begin
        w_c  = w_sum[MSB:0];
        w_cy = w_sum[WIDTH];
        w_f  = (I_A[MSB] == I_B[MSB]) & (w_sum[MSB] != I_A[MSB]);
      end
      4'd3: w_c = I_A * I_B;
      4'd4, 4'd5, 4'd6, 4'd7: begin
        w_is_sub = 1'b1;
        w_c      = w_diff[MSB:0];
        w_cy     = w_diff[WIDTH];
        w_f      = (I_A[MSB] != I_B[MSB]) & (w_diff[MSB] != I_B[MSB]);
        w_l      = I_B < I_A;
      end
      4'd8:  w_c = I_A & I_B;
      4'd9:  w_c = I_A | I_B;
      4'd10: w_c = I_A ^ I_B;
      4'd11: w_c = ~I_A;
      4'd12: w_c = I_B << I_A[3:0];
      4'd13: w_c = $signed(I_B) >>> I_A[3:0];
      default: w_c = '0;
    endcase
    w_n = w_is_sub ? ($signed(I_B) < $signed(I_A)) : w_c[MSB];
    // Opcodes 14 and 15 are unused, so they report no status at all.
    w_z = (w_c == '0) & (I_OPCODE <= 4'd13);
  end

  assign O_C      = I_ENABLE ? w_c : '0;
  assign O_STATUS = I_ENABLE ? {w_n, w_z, w_f, w_l, w_cy} : 5'b0;
endmodule
